nor_chain_pipe: RTL and testbench



---
 rtl/nor_chain_pipe.sv | 118 +++++++++++
 tb/tb_nor_chain_pipe.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nor_chain_pipe.sv
// Pipelined N_IN-input cascaded NOR chain exposing every tap, with valid/ready flow control.
// Optional transfer counter on port xfer_cnt when NOR_CHAIN_PIPE_CNT_EN is defined.
module nor_chain_pipe #(
  parameter int N_IN           = 4,
  parameter int STAGES_PER_REG = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N_IN-2:0] out_taps,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_nor
`ifdef NOR_CHAIN_PIPE_CNT_EN
  ,
  output logic [15:0]     xfer_cnt
`endif
);

  localparam int NST = N_IN - 1;
  localparam int L   = (NST + STAGES_PER_REG - 1) / STAGES_PER_REG;

  logic w_adv;

  // Global stall: every slice advances together whenever the output slot is free.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar j = 0; j < L; j++) begin : g_slice
    localparam int LO = j * STAGES_PER_REG;
    localparam int HI = ((j + 1) * STAGES_PER_REG < NST) ? (j + 1) * STAGES_PER_REG : NST;

    logic [HI-1:0] w_taps;
    logic [HI-1:0] r_taps;
    logic          w_vld;
    logic          r_vld;

    if (j == 0) begin : g_first
      assign w_vld = in_valid;

      always_comb begin : p_nor
        logic [HI-1:0] v;
        v     = '0;
        v[LO] = ~(in_data[0] | in_data[1]);
        for (int k = LO + 1; k < HI; k++) begin
          v[k] = ~(v[k-1] | in_data[k+1]);
        end
        w_taps = v;
      end
    end else begin : g_rest
      assign w_vld = g_slice[j-1].r_vld;

      // Unconsumed operands arrive packed so that bit 0 is in_data[LO+1].
      always_comb begin : p_nor
        logic [HI-1:0] v;
        v         = '0;
        v[LO-1:0] = g_slice[j-1].r_taps;
        for (int k = LO; k < HI; k++) begin
          v[k] = ~(v[k-1] | g_slice[j-1].g_fwd.r_data[k-LO]);
        end
        w_taps = v;
      end
    end

    if (j < L - 1) begin : g_fwd
      localparam int DW = N_IN - 1 - HI;

      logic [DW-1:0] w_data;
      logic [DW-1:0] r_data;

      if (j == 0) begin : g_src_in
        assign w_data = in_data[N_IN-1:HI+1];
      end else begin : g_src_prev
        assign w_data = g_slice[j-1].g_fwd.r_data[N_IN-2-LO:HI-LO];
      end

      always_ff @(posedge clk) begin
        if (w_adv && w_vld) begin
          r_data <= w_data;
        end
      end
    end

    // ---- slice register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= 1'b0;
        r_taps <= '0;
      end else if (w_adv) begin
        r_vld <= w_vld;
        if (w_vld) begin
          r_taps <= w_taps;
        end
      end
    end
  end

  assign out_valid = g_slice[L-1].r_vld;
  assign out_taps  = g_slice[L-1].r_taps;
  assign out_nor   = g_slice[L-1].r_taps[NST-1];

`ifdef NOR_CHAIN_PIPE_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'h0000;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_nor_chain_pipe.sv
// Self-checking bench for nor_chain_pipe: default instance plus a parameter sweep of instances.
module tb_nor_chain_pipe;

  localparam int NC = 7;

  function automatic int cfg_n(input int c);
    case (c)
      0:       return 2;
      1, 2, 3: return 5;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_s(input int c);
    case (c)
      0, 1, 4: return 1;
      2, 5:    return 2;
      3:       return 4;
      default: return 7;
    endcase
  endfunction

  function automatic int cfg_lat(input int c);
    return (cfg_n(c) - 1 + cfg_s(c) - 1) / cfg_s(c);
  endfunction

  // Direct evaluation of the cascaded NOR equations for an n-input chain.
  function automatic logic [6:0] ref_taps(input logic [7:0] d, input int n);
    logic [6:0] t;
    t    = '0;
    t[0] = ~(d[0] | d[1]);
    for (int k = 1; k < n - 1; k++) t[k] = ~(t[k-1] | d[k+1]);
    return t;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] in_data;
  logic       in_valid, in_ready;
  logic [2:0] out_taps;
  logic       out_valid, out_ready, out_nor;
`ifdef NOR_CHAIN_PIPE_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [6:0] taps; int tag; } exp_t;
  typedef struct { logic [7:0] d; int tag; } sw_t;
  exp_t exp_q[$];
  sw_t  sw_q[$];

  nor_chain_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_taps(out_taps), .out_valid(out_valid), .out_ready(out_ready), .out_nor(out_nor)
`ifdef NOR_CHAIN_PIPE_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  logic [7:0]         sw_in;
  logic               sw_vld, sw_ordy;
  logic [NC-1:0]      sw_ird, sw_ov, sw_nor;
  logic [NC-1:0][6:0] sw_taps;
`ifdef NOR_CHAIN_PIPE_CNT_EN
  logic [NC-1:0][15:0] sw_cnt;
`endif

  for (genvar c = 0; c < NC; c++) begin : g_sw
    localparam int N = cfg_n(c);
    localparam int S = cfg_s(c);
    logic [N-2:0] taps;
    nor_chain_pipe #(.N_IN(N), .STAGES_PER_REG(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(sw_in[N-1:0]), .in_valid(sw_vld), .in_ready(sw_ird[c]),
      .out_taps(taps), .out_valid(sw_ov[c]), .out_ready(sw_ordy), .out_nor(sw_nor[c])
`ifdef NOR_CHAIN_PIPE_CNT_EN
      , .xfer_cnt(sw_cnt[c])
`endif
    );
    assign sw_taps[c] = 7'(taps);
  end

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    sw_vld = 1'b0; sw_in = '0; sw_ordy = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_taps !== 3'b000) begin errors++; $display("FAIL reset_out_taps: got %b expected 000", out_taps); end
    checks++; if (out_nor !== 1'b0) begin errors++; $display("FAIL reset_out_nor: got %b expected 0", out_nor); end
    checks++; if (sw_ov !== '0) begin errors++; $display("FAIL reset_sweep_valid: got %b expected 0", sw_ov); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 4'b0000; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      checks++;
      if (out_valid !== (e == 3)) begin
        errors++; $display("FAIL single_valid_edge%0d: got %b expected %b", e, out_valid, (e == 3));
      end
      if (e == 3) begin
        checks++; if (out_taps !== 3'b101) begin errors++; $display("FAIL single_taps: got %b expected 101", out_taps); end
        checks++; if (out_nor !== 1'b1) begin errors++; $display("FAIL single_nor: got %b expected 1", out_nor); end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] words [3];
    int obs;
    exp_t e;
    words[0] = 4'b0001; words[1] = 4'b1111; words[2] = 4'b0100;
    obs = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 3); in_data = words[(i < 3) ? i : 0]; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_word: got taps %b expected no word", out_taps);
        end else begin
          if (out_taps !== exp_q[0].taps[2:0] || out_nor !== exp_q[0].taps[2]) begin
            errors++; $display("FAIL b2b_taps: got %b/%b expected %b", out_taps, out_nor, exp_q[0].taps[2:0]);
          end
          checks++;
          if (cyc - exp_q[0].tag !== 3) begin
            errors++; $display("FAIL b2b_latency: got %0d expected 3", cyc - exp_q[0].tag);
          end
          void'(exp_q.pop_front());
          obs++;
        end
      end
      if (in_valid && in_ready) begin
        e.taps = ref_taps({4'b0000, in_data}, 4); e.tag = cyc; exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    checks++; if (obs !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", obs); end
  endtask

  task automatic test_stall();
    int pushed, obs;
    logic [2:0] held;
    exp_t e;
    pushed = 0; obs = 0; held = '0;
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      in_valid  = (i < 11);
      in_data   = 4'(i * 5 + 1);
      out_ready = !(i >= 3 && i < 8);
      #1;
      if (i == 3 && exp_q.size() != 0) held = exp_q[0].taps[2:0];
      if (i >= 3 && i < 8) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c%0d: got %b expected 0", i, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid c%0d: got %b expected 1", i, out_valid); end
        checks++; if (out_taps !== held) begin errors++; $display("FAIL stall_hold c%0d: got %b expected %b", i, out_taps, held); end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra_word: got taps %b expected no word", out_taps);
        end else begin
          if (out_taps !== exp_q[0].taps[2:0] || out_nor !== exp_q[0].taps[2]) begin
            errors++; $display("FAIL stall_order: got %b/%b expected %b", out_taps, out_nor, exp_q[0].taps[2:0]);
          end
          if (out_ready) begin void'(exp_q.pop_front()); obs++; end
        end
      end
      if (in_valid && in_ready) begin
        e.taps = ref_taps({4'b0000, in_data}, 4); e.tag = cyc; exp_q.push_back(e); pushed++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (obs !== pushed) begin errors++; $display("FAIL stall_count: got %0d expected %0d", obs, pushed); end
    checks++; if (pushed !== 6) begin errors++; $display("FAIL stall_accepted: got %0d expected 6", pushed); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = (i == 0) ? 4'b0000 : 4'(i + 8);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    checks++; if (out_taps !== 3'b101) begin errors++; $display("FAIL midrst_pre_taps: got %b expected 101", out_taps); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", out_valid); end
    checks++; if (out_taps !== 3'b000) begin errors++; $display("FAIL midrst_taps: got %b expected 000", out_taps); end
    checks++; if (out_nor !== 1'b0) begin errors++; $display("FAIL midrst_nor: got %b expected 0", out_nor); end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c%0d: got %b expected 0", i, out_valid); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    int pushed, obs;
    exp_t e;
    pushed = 0; obs = 0;
    exp_q.delete();
    for (int i = 0; i < 320; i++) begin
      in_valid  = (i < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data   = 4'($urandom);
      out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_word: got taps %b expected no word", out_taps);
        end else begin
          if (out_taps !== exp_q[0].taps[2:0] || out_nor !== exp_q[0].taps[2]) begin
            errors++; $display("FAIL rand_taps: got %b/%b expected %b", out_taps, out_nor, exp_q[0].taps[2:0]);
          end
          if (out_ready) begin void'(exp_q.pop_front()); obs++; end
        end
      end
      if (in_valid && in_ready) begin
        e.taps = ref_taps({4'b0000, in_data}, 4); e.tag = cyc; exp_q.push_back(e); pushed++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (obs !== pushed) begin errors++; $display("FAIL rand_count: got %0d expected %0d", obs, pushed); end
  endtask

  task automatic test_sweep();
    int  rd [NC];
    sw_t s;
    logic [6:0] exp;
    sw_q.delete();
    for (int c = 0; c < NC; c++) rd[c] = 0;
    sw_ordy = 1'b1;
    for (int i = 0; i < 70; i++) begin
      sw_vld = (i < 60) ? ($urandom_range(0, 3) != 0) : 1'b0;
      sw_in  = 8'($urandom);
      #1;
      for (int c = 0; c < NC; c++) begin
        checks++; if (sw_ird[c] !== 1'b1) begin errors++; $display("FAIL sweep%0d_in_ready: got %b expected 1", c, sw_ird[c]); end
        if (sw_ov[c]) begin
          checks++;
          if (rd[c] >= sw_q.size()) begin
            errors++; $display("FAIL sweep%0d_extra_word: got %b expected no word", c, sw_taps[c]);
          end else begin
            exp = ref_taps(sw_q[rd[c]].d, cfg_n(c));
            if (sw_taps[c] !== exp || sw_nor[c] !== exp[cfg_n(c)-2]) begin
              errors++; $display("FAIL sweep%0d_taps: got %b/%b expected %b", c, sw_taps[c], sw_nor[c], exp);
            end
            checks++;
            if (cyc - sw_q[rd[c]].tag !== cfg_lat(c)) begin
              errors++; $display("FAIL sweep%0d_latency: got %0d expected %0d", c, cyc - sw_q[rd[c]].tag, cfg_lat(c));
            end
            rd[c]++;
          end
        end
      end
      if (sw_vld) begin s.d = sw_in; s.tag = cyc; sw_q.push_back(s); end
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (rd[c] !== sw_q.size()) begin errors++; $display("FAIL sweep%0d_count: got %0d expected %0d", c, rd[c], sw_q.size()); end
    end
  endtask

`ifdef NOR_CHAIN_PIPE_CNT_EN
  task automatic test_xfer_cnt();
    logic [15:0] mcnt;
    int acc, obs;
    mcnt = '0; acc = 0; obs = 0;
    in_valid = 1'b0; out_ready = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (xfer_cnt !== 16'h0000) begin errors++; $display("FAIL cnt_reset: got %h expected 0000", xfer_cnt); end
    for (int i = 0; i < 70000 && obs < 65537; i++) begin
      in_valid  = (acc < 65537);
      in_data   = 4'(i);
      out_ready = !(i >= 100 && i < 105);
      #1;
      if (i % 4096 == 0 || (i >= 99 && i < 106)) begin
        checks++; if (xfer_cnt !== mcnt) begin errors++; $display("FAIL cnt_track c%0d: got %h expected %h", i, xfer_cnt, mcnt); end
      end
      if (out_valid && out_ready) begin mcnt = mcnt + 16'd1; obs++; end
      if (in_valid && in_ready) acc++;
      @(posedge clk);
      #1;
    end
    checks++; if (obs !== 65537) begin errors++; $display("FAIL cnt_transfers: got %0d expected 65537", obs); end
    checks++; if (xfer_cnt !== 16'h0001) begin errors++; $display("FAIL cnt_wrap: got %h expected 0001", xfer_cnt); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_midflight();
    test_random();
    test_sweep();
`ifdef NOR_CHAIN_PIPE_CNT_EN
    test_xfer_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
